// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the two-digit BCD 7-segment scanner.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    T_ON  = 2'd0,
    T_GAP = 2'd1,
    O_ON  = 2'd2,
    O_GAP = 2'd3
  } scan_state_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [1:0] COM_TENS = 2'b10;
  localparam logic [1:0] COM_ONES = 2'b01;
  localparam logic [1:0] COM_NONE = 2'b00;

endpackage

// File: rtl/bcd_seg_scan_if.sv
// Valid/ready handshake carrying one {tens, ones} BCD word.
interface bcd_seg_scan_if;
  logic [7:0] bcd_in;
  logic       bcd_valid;
  logic       bcd_ready;

  modport master (output bcd_in, output bcd_valid, input bcd_ready);
  modport slave  (input bcd_in, input bcd_valid, output bcd_ready);
endinterface

// File: rtl/bcd_seg_scan_seg7.sv
// Combinational BCD nibble to active-high 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (nib)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Two-digit 7-segment scanner with guard gaps; new words swap in only at frame boundaries.
//   state | meaning
//   T_ON  | tens digit lit          T_GAP | all commons off
//   O_ON  | ones digit lit          O_GAP | all commons off, last cycle is the frame boundary
module bcd_seg_scan
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_seg_scan_if.slave    bus,
  input  logic             blank_lz,
  output logic [6:0]       seg,
  output logic [1:0]       com
);

  localparam int CNT_MAX = (SCAN_DIV > GUARD) ? SCAN_DIV : GUARD;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GUARD - 1);
  localparam logic [6:0] SEG_POL = {7{ACTIVE_LOW}};
  localparam logic [1:0] COM_POL = {2{ACTIVE_LOW}};

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] div_cnt, div_nxt;
  logic             tc, boundary, hs;
  logic [7:0]       disp_reg, pend_reg;
  logic             pend_full;
  logic [3:0]       nib;
  logic [6:0]       seg_dec, seg_nxt;
  logic [1:0]       com_nxt;

  assign bus.bcd_ready = ~pend_full;
  assign hs            = bus.bcd_valid && !pend_full;
  assign tc            = ((state == T_ON) || (state == O_ON)) ? (div_cnt == ON_LAST)
                                                              : (div_cnt == GAP_LAST);
  assign boundary      = (state == O_GAP) && tc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= T_ON;
      div_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt + CNT_W'(1);
    if (tc) begin
      div_nxt = '0;
      case (state)
        T_ON:    state_nxt = T_GAP;
        T_GAP:   state_nxt = O_ON;
        O_ON:    state_nxt = O_GAP;
        O_GAP:   state_nxt = T_ON;
        default: state_nxt = T_ON;
      endcase
    end
  end

  // A word accepted on the boundary edge itself waits for the next boundary (no bypass).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg  <= 8'h00;
      pend_reg  <= 8'h00;
      pend_full <= 1'b0;
    end else if (boundary && pend_full) begin
      disp_reg  <= pend_reg;
      pend_full <= 1'b0;
    end else if (hs) begin
      pend_reg  <= bus.bcd_in;
      pend_full <= 1'b1;
    end
  end

  assign nib = (state == T_ON) ? disp_reg[7:4] : disp_reg[3:0];

  bcd_to_seg7 u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  always_comb begin
    seg_nxt = SEG_OFF;
    com_nxt = COM_NONE;
    case (state)
      T_ON: begin
        if (!(blank_lz && (disp_reg[7:4] == 4'd0))) begin
          seg_nxt = seg_dec;
          com_nxt = COM_TENS;
        end
      end
      O_ON: begin
        seg_nxt = seg_dec;
        com_nxt = COM_ONES;
      end
      default: begin
        seg_nxt = SEG_OFF;
        com_nxt = COM_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_OFF ^ SEG_POL;
      com <= COM_NONE ^ COM_POL;
    end else begin
      seg <= seg_nxt ^ SEG_POL;
      com <= com_nxt ^ COM_POL;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan: accepted words queue up and are retired at frame boundaries.
module tb_bcd_seg_scan;

  localparam int SD    = 4;
  localparam int GD    = 1;
  localparam int FRAME = 2 * (SD + GD);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic [1:0] com;

  bcd_seg_scan_if bus();

  bcd_seg_scan #(.SCAN_DIV(SD), .GUARD(GD), .ACTIVE_LOW(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .blank_lz (blank_lz),
    .seg      (seg),
    .com      (com)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb[$];
  logic [7:0] m_disp = 8'h00;
  int         cyc = 0;
  bit         have_exp = 1'b0;
  bit         m_hs;
  logic [6:0] exp_seg = 7'h00;
  logic [1:0] exp_com = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Reference: cyc is the scan phase (0-3 tens, 4 gap, 5-8 ones, 9 gap/boundary).
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      sb.delete();
      m_disp   = 8'h00;
      cyc      = 0;
      have_exp = 1'b0;
    end else begin
      m_hs = bus.bcd_valid && (sb.size() == 0);
      if (cyc < SD) begin
        if (blank_lz && m_disp[7:4] == 4'd0) begin
          exp_com = 2'b00; exp_seg = 7'h00;
        end else begin
          exp_com = 2'b10; exp_seg = seg_of(m_disp[7:4]);
        end
      end else if (cyc >= SD + GD && cyc < 2 * SD + GD) begin
        exp_com = 2'b01; exp_seg = seg_of(m_disp[3:0]);
      end else begin
        exp_com = 2'b00; exp_seg = 7'h00;
      end
      if (cyc == FRAME - 1 && sb.size() != 0) m_disp = sb.pop_front();
      if (m_hs) sb.push_back(bus.bcd_in);
      cyc      = (cyc + 1) % FRAME;
      have_exp = 1'b1;
    end
  end

  always begin
    @(negedge clk);
    if (rst_n && have_exp) begin
      check("seg", {25'd0, seg}, {25'd0, exp_seg});
      check("com", {30'd0, com}, {30'd0, exp_com});
      check("ready", {31'd0, bus.bcd_ready}, {31'd0, sb.size() == 0});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] w);
    int n;
    bit ok;
    bus.bcd_in    = w;
    bus.bcd_valid = 1'b1;
    n = 0;
    forever begin
      ok = bus.bcd_ready;
      @(negedge clk);
      if (ok) break;
      n++;
      if (n > 3 * FRAME) begin
        check("send_accept", {31'd0, ok}, 32'd1);
        break;
      end
    end
    bus.bcd_valid = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_seg"}, {25'd0, seg}, 32'h00);
    check({tag, "_com"}, {30'd0, com}, 32'h0);
    check({tag, "_ready"}, {31'd0, bus.bcd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bus.bcd_in    = 8'h00;
    bus.bcd_valid = 1'b0;
    #2;
    check("por_seg", {25'd0, seg}, 32'h00);
    check("por_com", {30'd0, com}, 32'h0);
    check("por_ready", {31'd0, bus.bcd_ready}, 32'd1);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Reset asserted while the ones digit is lit
    n = 0;
    while (cyc != SD + GD + 1 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_com", {30'd0, com}, 32'h1);
    async_reset_check("rst_mid");
    idle(12);

    send(8'h15);
    idle(25);

    send(8'h23);
    send(8'h45);
    idle(35);

    blank_lz = 1'b1;
    send(8'h07);
    idle(25);
    blank_lz = 1'b0;
    idle(12);

    send(8'h3C);
    idle(25);
    send(8'h68);
    idle(25);
    send(8'hF9);
    idle(25);

    // Pending word lost on reset while 99 is on display
    send(8'h99);
    idle(25);
    send(8'h12);
    idle(2);
    async_reset_check("rst_pend");
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream consumer of the 8-bit BCD produced by the binary-to-BCD converter: {tens[7:4], ones[3:0]}.
- Latches BCD words through a valid/ready handshake and time-multiplexes two common-cathode/anode 7-segment digits.
- Uses a scan state machine with anti-ghosting guard gaps.
- New values are applied only at frame boundaries, so no frame ever shows a mix of old and new digits.

Parameters:
SCAN_DIV, 50000, clock cycles each digit is lit per frame (>=2)
GUARD, 16, clock cycles with all commons off between digit slots (>=1)
ACTIVE_LOW, 1, 1: seg and com outputs are active-low; 0: active-high

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bcd_in  input  8  {tens, ones} BCD word
bcd_valid  input  1  bcd_in is valid this cycle
bcd_ready  output  1  block can accept a word; transfer occurs when bcd_valid && bcd_ready on a clk rising edge
blank_lz  input  1  1: suppress the tens digit when it is 0
seg  output  7  segments {g,f,e,d,c,b,a}, registered
com  output  2  digit commons, com[1]=tens, com[0]=ones, registered

Behaviour:
- One clock domain. Reset is asynchronous and active-low. All state resets immediately on rst_n falling edge.
- Reset values:
  - state=T_ON, div_cnt=0, disp_reg=8'h00, pend_full=0.
  - seg=all off, com=all off. With ACTIVE_LOW=1 that is seg=7'h7F, com=2'b11; with ACTIVE_LOW=0 both are all zeros.
  - bcd_ready=1, because it is the combinational inverse of pend_full.
- Input buffer:
  - One pending register.
  - On handshake: pend_reg<=bcd_in, pend_full<=1.
  - bcd_ready = ~pend_full.
- FSM states: T_ON -> T_GAP -> O_ON -> O_GAP -> T_ON.
  - div_cnt counts 0..SCAN_DIV-1 in the ON states and 0..GUARD-1 in the GAP states.
  - On the terminal count: advance state and clear div_cnt. Otherwise increment div_cnt.
  - Frame period = 2*(SCAN_DIV+GUARD) cycles.
- Frame boundary is the O_GAP terminal-count cycle. At that edge, if pend_full: disp_reg<=pend_reg, pend_full<=0.
- Simultaneous events at the boundary:
  - Boundary with pend_full=0 and a handshake in the same cycle: the word goes into pend_reg only. It is displayed at the following boundary. There is no bypass.
  - Boundary with pend_full=1: the transfer clears pend_full. bcd_ready rises the next cycle.
- Latency:
  - Accepted word first appears in the T_ON slot after the next frame boundary.
  - Worst case is 2*(SCAN_DIV+GUARD)+1 cycles from acceptance to first visibility.
  - Output registers add one cycle after each state change.
- Output decode (active-high shown; invert both seg and com when ACTIVE_LOW=1):
  - T_ON: com=2'b10, seg=dec(disp_reg[7:4]).
  - O_ON: com=2'b01, seg=dec(disp_reg[3:0]).
  - GAP states: com=2'b00, seg=7'h00.
- Leading-zero blanking: in T_ON, if blank_lz=1 and disp_reg[7:4]==0, then com=2'b00 and seg=7'h00. blank_lz is sampled live; it is not latched with the data.
- Decoder values (active-high):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any nibble 10..15 shows a dash = 7'h40 (segment g only).
- Reset mid-operation discards both the pending word and the displayed word. After release, scanning restarts at T_ON with div_cnt=0.

Decomposition:
- Package bcd_disp_pkg holds:
  - The scan state enum (T_ON, T_GAP, O_ON, O_GAP).
  - Segment constants SEG_0..SEG_9, SEG_DASH=7'h40, SEG_OFF=7'h00.
  - Common-select constants COM_TENS=2'b10, COM_ONES=2'b01, COM_NONE=2'b00.
- One combinational sub-module, bcd_to_seg7 (4-bit nibble in, 7-bit active-high segments out). It is instantiated once and its input is muxed by state.
- Polarity inversion happens only at the output registers.

Test Plan:
(all scenarios: SCAN_DIV=4, GUARD=1, ACTIVE_LOW=0; frame = 10 cycles)
1. Reset: assert rst_n=0 mid-O_ON -> seg=7'h00, com=2'b00, bcd_ready=1 with no clock edge. Release -> T_ON with tens showing 7'h3F.
2. Handshake bcd_in=8'h15 -> after the next boundary:
   - com=10, seg=7'h06 for 4 cycles.
   - com=00 for 1 cycle.
   - com=01, seg=7'h6D for 4 cycles.
   - com=00 for 1 cycle.
   - Repeats every 10 cycles.
3. Back-pressure: valid 8'h23 then 8'h45 in consecutive cycles within one frame -> 8'h23 accepted, bcd_ready=0 and 8'h45 held. At the boundary 23 is displayed, and 8'h45 is accepted the cycle after. Display shows 45 one frame later.
4. Blanking: 8'h07 with blank_lz=1 -> tens slot com=00, seg=00; ones slot seg=7'h07. Same word with blank_lz=0 -> tens slot seg=7'h3F.
5. Invalid BCD: 8'h3C -> tens seg=7'h4F, ones seg=7'h40 (dash).
6. Reset with pend_full=1 and disp=8'h99 -> after release disp=00, bcd_ready=1, and the pending word never appears.
